// File: rtl/zfb_memory.sv
// Combined depth buffer and colour framebuffer with a hardware clear engine.
// Depth reads are registered with write-first bypass; scan-out reads are registered.
module zfb_memory #(
  parameter int H_RES  = 320,
  parameter int V_RES  = 240,
  parameter int PIX_W  = 12,
  parameter int Z_W    = 8,
  parameter int ADDR_W = 17,
  parameter logic [PIX_W-1:0] CLEAR_COLOR = '0,
  parameter logic [Z_W-1:0]   Z_FAR       = '1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clear,
  output logic              o_busy,
  output logic              o_clear_done,
  input  logic [ADDR_W-1:0] i_zb_r_addr,
  output logic [Z_W-1:0]    o_zb_r_data,
  input  logic              i_zb_w_we,
  input  logic [ADDR_W-1:0] i_zb_w_addr,
  input  logic [Z_W-1:0]    i_zb_w_data,
  input  logic              i_fb_we,
  input  logic [ADDR_W-1:0] i_fb_addr,
  input  logic [PIX_W-1:0]  i_fb_pixel,
  input  logic              i_scan_re,
  input  logic [ADDR_W-1:0] i_scan_addr,
  output logic [PIX_W-1:0]  o_scan_pixel,
  output logic              o_scan_valid
);

  localparam int N     = H_RES * V_RES;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [ADDR_W:0]   N_L  = (ADDR_W + 1)'(N);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [Z_W-1:0]    zb_q, zb_d;
  logic [PIX_W-1:0]  pix_q, pix_d;
  logic              vld_q, vld_d;

  logic [Z_W-1:0]    zmem   [0:N-1];
  logic [PIX_W-1:0]  cmem   [0:N-1];

  logic              clearing;
  logic              zr_ok, zw_ok, fw_ok, sr_ok;
  logic              z_we, c_we;
  logic [IDX_W-1:0]  z_widx, c_widx;
  logic [Z_W-1:0]    z_wdat;
  logic [PIX_W-1:0]  c_wdat;

  assign clearing = (state_q == S_CLEAR);
  assign zr_ok    = ({1'b0, i_zb_r_addr} < N_L);
  assign zw_ok    = ({1'b0, i_zb_w_addr} < N_L);
  assign fw_ok    = ({1'b0, i_fb_addr}   < N_L);
  assign sr_ok    = ({1'b0, i_scan_addr} < N_L);

  // Clear sequencer: IDLE -> CLEAR (one word per cycle) -> DONE -> IDLE
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (i_clear) begin
          state_d = S_CLEAR;
          cnt_d   = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CLEAR: begin
        cnt_d = cnt_q + ADDR_W'(1);
        if (cnt_q == LAST) begin
          state_d = S_DONE;
        end else begin
          state_d = S_CLEAR;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_CLEAR);
    done_d = (state_d == S_DONE);
  end

  // Write port muxing: the clear engine owns both memories while clearing
  always_comb begin
    if (clearing) begin
      z_we   = 1'b1;
      c_we   = 1'b1;
      z_widx = cnt_q[IDX_W-1:0];
      c_widx = cnt_q[IDX_W-1:0];
      z_wdat = Z_FAR;
      c_wdat = CLEAR_COLOR;
    end else begin
      z_we   = i_zb_w_we & zw_ok;
      c_we   = i_fb_we & fw_ok;
      z_widx = i_zb_w_addr[IDX_W-1:0];
      c_widx = i_fb_addr[IDX_W-1:0];
      z_wdat = i_zb_w_data;
      c_wdat = i_fb_pixel;
    end
  end

  // Read-data next state, including same-address depth bypass
  always_comb begin
    if (clearing || !zr_ok) begin
      zb_d = Z_FAR;
    end else if (i_zb_w_we && zw_ok && (i_zb_w_addr == i_zb_r_addr)) begin
      zb_d = i_zb_w_data;
    end else begin
      zb_d = zmem[i_zb_r_addr[IDX_W-1:0]];
    end
    if (i_scan_re) begin
      pix_d = sr_ok ? cmem[i_scan_addr[IDX_W-1:0]] : CLEAR_COLOR;
    end else begin
      pix_d = pix_q;
    end
    vld_d = i_scan_re;
  end

  // Control and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      zb_q    <= Z_FAR;
      pix_q   <= CLEAR_COLOR;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      zb_q    <= zb_d;
      pix_q   <= pix_d;
      vld_q   <= vld_d;
    end
  end

  // Memory arrays are never reset; reset only blocks the write
  always_ff @(posedge clk) begin
    if (!rst && z_we) begin
      zmem[z_widx] <= z_wdat;
    end
    if (!rst && c_we) begin
      cmem[c_widx] <= c_wdat;
    end
  end

  assign o_busy       = busy_q;
  assign o_clear_done = done_q;
  assign o_zb_r_data  = zb_q;
  assign o_scan_pixel = pix_q;
  assign o_scan_valid = vld_q;

endmodule

// File: doc/zfb_memory.md
ZFB_MEMORY -- requirements
Module: zfb_memory

Interface
REQ-001 SHALL have parameter H_RES, default 320, horizontal pixels per line.
REQ-002 SHALL have parameter V_RES, default 240, number of lines.
REQ-003 SHALL have parameter PIX_W, default 12, colour word width (4R/4G/4B).
REQ-004 SHALL have parameter Z_W, default 8, depth word width.
REQ-005 SHALL have parameter ADDR_W, default 17, address width, at least clog2(H_RES*V_RES).
REQ-006 SHALL have parameter CLEAR_COLOR, default 0, colour written by clear.
REQ-007 SHALL have parameter Z_FAR, default all-ones, depth written by clear and returned for invalid reads.
REQ-008 SHALL have the following ports, clock and reset first:
- clk  in  1  single clock, all logic on its rising edge
- rst  in  1  synchronous, active-high reset
- i_clear  in  1  clear request, sampled each cycle
- o_busy  out  1  clear in progress
- o_clear_done  out  1  one-cycle pulse at clear completion
- i_zb_r_addr  in  ADDR_W  depth read address
- o_zb_r_data  out  Z_W  depth read data
- i_zb_w_we  in  1  depth write enable
- i_zb_w_addr  in  ADDR_W  depth write address
- i_zb_w_data  in  Z_W  depth write data
- i_fb_we  in  1  colour write enable
- i_fb_addr  in  ADDR_W  colour write address
- i_fb_pixel  in  PIX_W  colour write data
- i_scan_re  in  1  scan-out read enable
- i_scan_addr  in  ADDR_W  scan-out read address
- o_scan_pixel  out  PIX_W  scan-out colour data
- o_scan_valid  out  1  o_scan_pixel valid

Function
REQ-009 SHALL hold N=H_RES*V_RES depth words and N colour words; address = y*H_RES+x.
REQ-010 SHALL return o_zb_r_data one cycle after i_zb_r_addr is presented, every cycle, no enable.
REQ-011 SHALL, on a depth read and depth write to the same address in the same cycle, return the newly written data (write-first bypass).
REQ-012 SHALL commit depth and colour writes at the clock edge on which the enable is sampled high.
REQ-013 SHALL ignore writes with address >= N; reads with address >= N SHALL return Z_FAR (depth) or CLEAR_COLOR (scan).
REQ-014 SHALL drive o_scan_pixel and o_scan_valid one cycle after i_scan_re; o_scan_valid=0 the cycle after i_scan_re=0, and o_scan_pixel then holds its previous value.
REQ-015 SHALL implement FSM states IDLE, CLEAR, DONE.
REQ-016 SHALL, in IDLE with i_clear=1, go to CLEAR and zero the clear counter.
REQ-017 SHALL, in CLEAR, write Z_FAR and CLEAR_COLOR at the counter address each cycle, increment the counter, and go to DONE after writing address N-1.
REQ-018 SHALL, in DONE, assert o_clear_done for exactly one cycle, then return to IDLE.
REQ-019 SHALL assert o_busy exactly in CLEAR; a clear takes N cycles of o_busy.
REQ-020 SHALL ignore i_clear while in CLEAR or DONE (no queueing).
REQ-021 SHALL, during CLEAR, discard external depth/colour writes and return Z_FAR on depth reads; scan reads SHALL return memory contents.

Reset
REQ-022 SHALL, with rst=1 at a clock edge, set state IDLE, counter 0, o_busy=0, o_clear_done=0, o_scan_valid=0, o_zb_r_data=Z_FAR, o_scan_pixel=CLEAR_COLOR.
REQ-023 SHALL NOT alter memory contents on reset; reset during CLEAR aborts the clear, leaves already-written locations cleared and produces no o_clear_done.
REQ-024 SHALL give rst priority over i_clear and all writes in the same cycle.

Verification (H_RES=4, V_RES=2, N=8 unless stated)
REQ-025 Write depth 0x12 to addr 3, read addr 3 next cycle -> o_zb_r_data=0x12 one cycle later; same-cycle read+write 0x34 to addr 5 -> 0x34.
REQ-026 i_clear pulse -> o_busy high 8 cycles, o_clear_done single pulse the following cycle, all depth reads 0xFF, all scan reads 0x000.
REQ-027 Colour write 0xABC to addr 2 during CLEAR -> discarded; after clear scan addr 2 = 0x000; i_clear during busy -> no second clear.
REQ-028 Write to addr 9 (>= N) -> no change; depth read addr 9 -> 0xFF.
REQ-029 rst asserted on 4th CLEAR cycle -> o_busy=0 next cycle, no o_clear_done, addrs 0-2 cleared, addrs 4-7 keep prior values.
REQ-030 Default params, 320x240: clear -> o_busy exactly 76800 cycles; scan addr 76799 after colour write 0xF0F -> 0xF0F with o_scan_valid=1.
